universal_shift_reg_n: RTL and testbench
========================================

# universal_shift_reg_n

- Parametrised universal shift register: the next generation of the team's 4-bit 74LS194-style block, with the same mode encoding.
- Adds WIDTH-bit data, serial-out taps and a counted burst-shift engine with `busy`/`done` handshake.
- Used in the wall-clock display path for digit/segment shifting and in later lab designs.

## Interface
Parameters:
- WIDTH, 8, register width (≥2); bit 0 is the QA end.
- CNT_W, 4, width of the burst count.

Ports:
- clk  in  1  rising-edge clock.
- CR  in  1  clear; one clock; reset is asynchronous and active-low.
- S1, S0  in  1 each  mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- D  in  WIDTH  parallel load data.
- SR  in  1  serial input for shift right, enters Q[0].
- SL  in  1  serial input for shift left, enters Q[WIDTH-1].
- start  in  1  request a counted burst.
- count  in  CNT_W  number of shifts in the burst.
- Q  out  WIDTH  register contents.
- SO_R  out  1  = Q[WIDTH-1], combinational.
- SO_L  out  1  = Q[0], combinational.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after the final burst shift.

## Operation
- **States:** IDLE and BURST. An internal `rem` counter (CNT_W bits) and a latched direction are held.
- **Reset (CR=0):** immediate, independent of clk.
  - Q=0, SO_R=0, SO_L=0, busy=0, done=0, rem=0, state=IDLE.
  - Applies mid-burst: the burst is abandoned and no done pulse is produced.
- **Shift right:** Q[i] <= Q[i-1] for i≥1; Q[0] <= SR.
- **Shift left:** Q[i] <= Q[i+1] for i<WIDTH-1; Q[WIDTH-1] <= SL.
- **IDLE with start=0:** the mode S1S0 executes every edge (hold / right / left / load Q<=D).
- **IDLE with start=1:**
  - S1S0 = 01 or 10 and count≠0: latch the direction, rem<=count, busy<=1, go to BURST. Q is unchanged on this edge.
  - S1S0 = 00 or 11, or count=0: the direct mode operation executes, start is ignored and no done pulse is produced.
- **BURST:** every edge shifts in the latched direction and decrements rem.
  - S1, S0, start, count and D are ignored.
  - SR/SL are sampled live on each shift edge.
  - On the edge where rem==1: shift, rem<=0, busy<=0, done<=1, go to IDLE.
- **done:** deasserts on the following edge unless a new burst completes there. Back-to-back bursts cannot overlap, so done is never held high for two consecutive cycles.
- **start during BURST:** dropped, not queued.
- **Width rules:**
  - count is unsigned; the maximum burst is 2^CNT_W−1 shifts.
  - A burst longer than WIDTH simply continues filling from serial input (or rotation).

## Timing
- All state changes occur on the rising clk edge, except clear.
- **Direct-mode latency:** Q is updated at the first edge sampling the mode.
- **Burst latency:**
  - Start sampled at edge E0.
  - Shifts occur at E1..E_count.
  - busy is high from E0 to E_count, i.e. count cycles.
  - done is high for exactly the cycle after E_count.
  - The next start is accepted at E_count+1.
- SO_R and SO_L follow Q combinationally with no added latency.
- **CR release:** the first edge with CR=1 performs normal IDLE operation.

## Configuration
- Macro: USR_ROTATE_EN.
- **Defined:**
  - Adds input port `rot` (1 bit).
  - When rot=1 at a shift edge (direct or burst), the shift-right fill is Q[WIDTH-1] and the shift-left fill is Q[0].
  - rot is sampled per edge; SR/SL are ignored while rot=1.
- **Undefined:** no rot port; fills always come from SR/SL.

## Test plan
The bench uses WIDTH=4, CNT_W=4 and shows Q as Q[3:0].

1. **Asynchronous clear:** load 1010, then drive CR=0 between edges. Required: Q=0000, busy=0 and done=0 immediately, before the next edge.
2. **Load and hold:**
   - Stimulus: S1S0=11 with D=1010 for one edge, then S1S0=00 for 3 edges.
   - Required: Q=1010 throughout; SO_R=1, SO_L=0.
3. **Shift right fill:** from 0000, SR=1, S1S0=01 for 4 edges. Required: Q=0001, 0011, 0111, 1111.
4. **Burst left:**
   - Stimulus: from Q=1111, start=1, S1S0=10, count=3, SL=0; drive S1S0=11 during the burst.
   - Required Q sequence: 0111, 0011, 0001.
   - Required: busy high for 3 cycles, a single done pulse after the third shift, and the load mode ignored.
5. **Reset mid-burst:**
   - Stimulus: count=10 right burst; assert CR=0 after 4 shifts; release and apply S1S0=11 with D=0110.
   - Required: Q=0000, busy=0 and no done while cleared; Q=0110 after the load.
6. **Rotation (USR_ROTATE_EN defined):**
   - Stimulus: from Q=1001, rot=1, one right shift; reload 1001, one left shift.
   - Required: 0011 after the right shift, 1100 after the left shift; SR=0 and SL=0 have no effect.

Source files
------------

// File: rtl/universal_shift_reg_n.sv
// WIDTH-bit 74LS194-style universal shift register with a counted burst-shift engine.
// Optional rotation fill is enabled by defining USR_ROTATE_EN, which adds the rot input.
module universal_shift_reg_n #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             CR,
   input  logic             S1,
   input  logic             S0,
   input  logic [WIDTH-1:0] D,
   input  logic             SR,
   input  logic             SL,
`ifdef USR_ROTATE_EN
   input  logic             rot,
`endif
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] Q,
   output logic             SO_R,
   output logic             SO_L,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, BURST} state_t;
   typedef enum logic [1:0] {
      M_HOLD  = 2'b00,
      M_RIGHT = 2'b01,
      M_LEFT  = 2'b10,
      M_LOAD  = 2'b11
   } mode_t;

   state_t           state;
   logic [CNT_W-1:0] rem;
   logic             dir_left;
   mode_t            mode;
   logic             fill_r;
   logic             fill_l;
   logic [WIDTH-1:0] q_shr;
   logic [WIDTH-1:0] q_shl;
   logic             burst_req;

   assign mode = mode_t'({S1, S0});

`ifdef USR_ROTATE_EN
   // With rot set, each end is fed from the opposite end instead of the serial inputs.
   assign fill_r = rot ? Q[WIDTH-1] : SR;
   assign fill_l = rot ? Q[0]       : SL;
`else
   assign fill_r = SR;
   assign fill_l = SL;
`endif

   assign q_shr = {Q[WIDTH-2:0], fill_r};
   assign q_shl = {fill_l, Q[WIDTH-1:1]};

   assign burst_req = start && (mode == M_RIGHT || mode == M_LEFT) && (count != '0);

   assign SO_R = Q[WIDTH-1];
   assign SO_L = Q[0];

   // NOTE: every register here, including rem and the latched direction, is cleared by CR
   // and assigned with <= only, so all flops update together from the same pre-edge values.
   always_ff @(posedge clk or negedge CR) begin
      if (!CR) begin
         Q        <= '0;
         rem      <= '0;
         dir_left <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         state    <= IDLE;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (burst_req) begin
                  // Q holds on the accepting edge; shifting begins on the next one.
                  dir_left <= (mode == M_LEFT);
                  rem      <= count;
                  busy     <= 1'b1;
                  state    <= BURST;
               end else begin
                  case (mode)
                     M_RIGHT: Q <= q_shr;
                     M_LEFT:  Q <= q_shl;
                     M_LOAD:  Q <= D;
                     default: Q <= Q;
                  endcase
               end
            end
            BURST: begin
               Q   <= dir_left ? q_shl : q_shr;
               rem <= rem - CNT_W'(1);
               if (rem == CNT_W'(1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Directed self-checking bench for universal_shift_reg_n with WIDTH=4, CNT_W=4.
// Rotation steps are included only when USR_ROTATE_EN is defined.
module tb_universal_shift_reg_n;

   localparam int WIDTH = 4;
   localparam int CNT_W = 4;

   logic             clk;
   logic             CR;
   logic             S1, S0;
   logic [WIDTH-1:0] D;
   logic             SR, SL;
   logic             start;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] Q;
   logic             SO_R, SO_L, busy, done;
`ifdef USR_ROTATE_EN
   logic             rot;
`endif

   int n_cmp = 0;
   int n_err = 0;

   universal_shift_reg_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .CR    (CR),
      .S1    (S1),
      .S0    (S0),
      .D     (D),
      .SR    (SR),
      .SL    (SL),
`ifdef USR_ROTATE_EN
      .rot   (rot),
`endif
      .start (start),
      .count (count),
      .Q     (Q),
      .SO_R  (SO_R),
      .SO_L  (SO_L),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and sample 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mode(input logic [1:0] m);
      {S1, S0} = m;
   endtask

   initial begin
      CR = 1'b0; S1 = 1'b0; S0 = 1'b0; D = '0; SR = 1'b0; SL = 1'b0;
      start = 1'b0; count = '0;
`ifdef USR_ROTATE_EN
      rot = 1'b0;
`endif
      #3;
      check("reset_q",    Q,    4'b0000);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_sor",  SO_R, 1'b0);
      check("reset_sol",  SO_L, 1'b0);
      #9 CR = 1'b1;

      // 1. Asynchronous clear between edges
      set_mode(2'b11); D = 4'b1010;
      tick();
      check("t1_load", Q, 4'b1010);
      #2 CR = 1'b0;
      #1;
      check("t1_clr_q",    Q,    4'b0000);
      check("t1_clr_busy", busy, 1'b0);
      check("t1_clr_done", done, 1'b0);
      #1 CR = 1'b1;

      // 2. Load and hold
      set_mode(2'b11); D = 4'b1010;
      tick();
      check("t2_load", Q,    4'b1010);
      check("t2_sor",  SO_R, 1'b1);
      check("t2_sol",  SO_L, 1'b0);
      set_mode(2'b00); D = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_hold", Q, 4'b1010);
      end

      // 3. Shift right fill from 0000
      set_mode(2'b11); D = 4'b0000;
      tick();
      check("t3_zero", Q, 4'b0000);
      set_mode(2'b01); SR = 1'b1;
      tick(); check("t3_sr1", Q, 4'b0001);
      tick(); check("t3_sr2", Q, 4'b0011);
      tick(); check("t3_sr3", Q, 4'b0111);
      tick(); check("t3_sr4", Q, 4'b1111);
      check("t3_sor", SO_R, 1'b1);

      // 4. Burst left of 3, load mode ignored during burst
      start = 1'b1; set_mode(2'b10); count = 4'd3; SL = 1'b0; SR = 1'b0;
      tick();
      check("t4_e0_q",    Q,    4'b1111);
      check("t4_e0_busy", busy, 1'b1);
      check("t4_e0_done", done, 1'b0);
      start = 1'b0; set_mode(2'b11); D = 4'b1010;
      tick();
      check("t4_e1_q",    Q,    4'b0111);
      check("t4_e1_busy", busy, 1'b1);
      check("t4_e1_done", done, 1'b0);
      tick();
      check("t4_e2_q",    Q,    4'b0011);
      check("t4_e2_busy", busy, 1'b1);
      check("t4_e2_done", done, 1'b0);
      set_mode(2'b00);
      tick();
      check("t4_e3_q",    Q,    4'b0001);
      check("t4_e3_busy", busy, 1'b0);
      check("t4_e3_done", done, 1'b1);
      tick();
      check("t4_e4_q",    Q,    4'b0001);
      check("t4_e4_done", done, 1'b0);

      // count=0 with start: direct right shift, no burst
      start = 1'b1; set_mode(2'b01); count = 4'd0; SR = 1'b0;
      tick();
      check("cnt0_q",    Q,    4'b0010);
      check("cnt0_busy", busy, 1'b0);
      check("cnt0_done", done, 1'b0);
      // start with load mode: load executes, no burst
      set_mode(2'b11); count = 4'd5; D = 4'b0001;
      tick();
      check("startld_q",    Q,    4'b0001);
      check("startld_busy", busy, 1'b0);

      // 5. Reset mid-burst: count=10 right burst, SR=1
      start = 1'b1; set_mode(2'b01); count = 4'd10; SR = 1'b1;
      tick();
      check("t5_e0_q",    Q,    4'b0001);
      check("t5_e0_busy", busy, 1'b1);
      start = 1'b0; set_mode(2'b00);
      tick(); check("t5_s1", Q, 4'b0011);
      tick(); check("t5_s2", Q, 4'b0111);
      tick(); check("t5_s3", Q, 4'b1111);
      tick(); check("t5_s4", Q, 4'b1111);
      check("t5_s4_busy", busy, 1'b1);
      #2 CR = 1'b0;
      #1;
      check("t5_clr_q",    Q,    4'b0000);
      check("t5_clr_busy", busy, 1'b0);
      check("t5_clr_done", done, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("t5_held_q",    Q,    4'b0000);
         check("t5_held_done", done, 1'b0);
      end
      #2 CR = 1'b1;
      set_mode(2'b11); D = 4'b0110;
      tick();
      check("t5_load_q",    Q,    4'b0110);
      check("t5_load_busy", busy, 1'b0);
      check("t5_load_done", done, 1'b0);
      set_mode(2'b00);
      tick();
      check("t5_after_q",    Q,    4'b0110);
      check("t5_after_busy", busy, 1'b0);

`ifdef USR_ROTATE_EN
      // 6. Rotation
      rot = 1'b1; SR = 1'b0; SL = 1'b0;
      set_mode(2'b11); D = 4'b1001;
      tick();
      check("t6_load1", Q, 4'b1001);
      set_mode(2'b01);
      tick();
      check("t6_rot_r", Q, 4'b0011);
      set_mode(2'b11); D = 4'b1001;
      tick();
      check("t6_load2", Q, 4'b1001);
      set_mode(2'b10);
      tick();
      check("t6_rot_l", Q, 4'b1100);
      rot = 1'b0; set_mode(2'b00);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
